// File: rtl/spram_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spram_adapter_pkg
// Purpose  : Shared types and constants for the SPRAM word adapter.
//            - state_t    : adapter sequencer states
//            - c_hw_sel_* : halfword select bit (LSB of the SPRAM address)
//            - c_spram_dw : SPRAM data width
//            - c_spram_mw : SPRAM nibble write-mask width
//            - strb2mask  : two byte enables -> four nibble enables
// Revision : 1.0 - initial release
// ============================================================================
package spram_adapter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_LO  = 3'd1,
        ACC_HI  = 3'd2,
        RD_TAIL = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic c_hw_sel_lo = 1'b0;
    localparam logic c_hw_sel_hi = 1'b1;
    localparam int   c_spram_dw  = 16;
    localparam int   c_spram_mw  = 4;

    // Each byte enable covers the two nibbles of its byte.
    function automatic logic [c_spram_mw-1:0] strb2mask(input logic [1:0] strb);
        return {strb[1], strb[1], strb[0], strb[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spram_word_adapter.sv
`default_nettype none
// ============================================================================
// Module   : spram_word_adapter
// Purpose  : Turns 32-bit CPU load/store requests into two sequenced halfword
//            accesses (low then high) on a 16-bit single-port RAM.
// Ports    : clk, reset                  - clock, sync active-high reset
//            req_valid/ready/addr/we/wdata/wstrb - CPU request
//            resp_valid/rdata/err        - completion pulse, load data, error
//            mem_addr/din/maskwren/wren  - SPRAM drive
//            mem_dout                    - SPRAM read data (1-cycle latency)
// Options  : SPRAM_ADAPTER_ERR_EN - out-of-window accesses are suppressed and
//            flagged on resp_err; otherwise addresses wrap and resp_err = 0.
// Revision : 1.0 - initial release
// ============================================================================
module spram_word_adapter
    import spram_adapter_pkg::*;
#(
    parameter int          HW_ADDR_W = 14,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_we,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [HW_ADDR_W-1:0]  mem_addr,
    output logic [c_spram_dw-1:0] mem_din,
    output logic [c_spram_mw-1:0] mem_maskwren,
    output logic                  mem_wren,
    input  logic [c_spram_dw-1:0] mem_dout
);

    localparam int c_word_w = HW_ADDR_W - 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_word_w-1:0]   r_word;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_err;
    logic [c_spram_dw-1:0] r_rdata_lo;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_wr_en;
    logic                  w_unused;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_wr_en  = r_we && !r_err;

    // Byte-offset bits and (when wrapping) the upper address bits are
    // deliberately ignored.
    assign w_unused = &{1'b0, req_addr[31:HW_ADDR_W+1], req_addr[1:0], MEM_BASE};

`ifdef SPRAM_ADAPTER_ERR_EN
    localparam logic [31:0] c_win_bytes = 32'd1 << (HW_ADDR_W + 1);
    logic [31:0] w_offset;

    // Unsigned subtract: addresses below MEM_BASE wrap high and also error.
    assign w_offset = req_addr - MEM_BASE;
    assign w_err    = (w_offset >= c_win_bytes);
    assign resp_err = r_err && (r_state == RESP);
`else
    assign w_err    = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_err      <= 1'b0;
            r_rdata_lo <= '0;
            resp_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_word  <= req_addr[HW_ADDR_W:2];
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_err   <= w_err;
            end
            // Low half is staged so resp_rdata only changes once the whole
            // word is in hand.
            if (r_state == ACC_HI && !r_we) begin
                r_rdata_lo <= mem_dout;
            end
            if (r_state == RD_TAIL) begin
                resp_rdata <= r_err ? 32'h0 : {mem_dout, r_rdata_lo};
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        mem_maskwren = '0;
        mem_wren     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ACC_LO;
                end
            end
            ACC_LO: begin
                mem_addr = {r_word, c_hw_sel_lo};
                mem_din  = r_wdata[15:0];
                if (w_wr_en) begin
                    mem_maskwren = strb2mask(r_wstrb[1:0]);
                    mem_wren     = 1'b1;
                end
                w_state_nxt = ACC_HI;
            end
            ACC_HI: begin
                mem_addr = {r_word, c_hw_sel_hi};
                mem_din  = r_wdata[31:16];
                if (w_wr_en) begin
                    mem_maskwren = strb2mask(r_wstrb[3:2]);
                    mem_wren     = 1'b1;
                end
                w_state_nxt = r_we ? RESP : RD_TAIL;
            end
            RD_TAIL: begin
                mem_addr    = {r_word, c_hw_sel_hi};
                w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spram_word_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spram_word_adapter
// Purpose  : Directed self-checking bench for spram_word_adapter with a
//            behavioural 16-bit nibble-masked SPRAM (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spram_word_adapter;

    localparam int HW_ADDR_W = 14;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_addr;
    logic                 req_we;
    logic [31:0]          req_wdata;
    logic [3:0]           req_wstrb;
    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic [HW_ADDR_W-1:0] mem_addr;
    logic [15:0]          mem_din;
    logic [3:0]           mem_maskwren;
    logic                 mem_wren;
    logic [15:0]          mem_dout;

    int n_vec    = 0;
    int n_miscmp = 0;

    always #5 clk = ~clk;

    spram_word_adapter #(
        .HW_ADDR_W (HW_ADDR_W),
        .MEM_BASE  (32'h0000_0000)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_maskwren (mem_maskwren),
        .mem_wren     (mem_wren),
        .mem_dout     (mem_dout)
    );

    // Behavioural SPRAM: nibble-masked write, registered read.
    logic [15:0] ram [0:(1<<HW_ADDR_W)-1];
    logic [15:0] w_bitmask;
    assign w_bitmask = {{4{mem_maskwren[3]}}, {4{mem_maskwren[2]}},
                        {4{mem_maskwren[1]}}, {4{mem_maskwren[0]}}};

    always @(posedge clk) begin
        if (mem_wren) begin
            ram[mem_addr] <= (ram[mem_addr] & ~w_bitmask) | (mem_din & w_bitmask);
        end
        mem_dout <= ram[mem_addr];
    end

    // Per-transaction observations, index = cycles after the accept edge.
    logic [HW_ADDR_W-1:0] s_addr  [8];
    logic [15:0]          s_din   [8];
    logic [3:0]           s_mask  [8];
    logic                 s_wren  [8];
    logic                 s_ready [8];
    logic                 s_pulse_after;
    int                   lat;
    logic [31:0]          got_rdata;
    logic                 got_err;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and follow it until resp_valid (bounded).
    task automatic txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [3:0] ws);
        req_valid  = 1'b1;
        req_addr   = a;
        req_we     = we;
        req_wdata  = wd;
        req_wstrb  = ws;
        s_ready[0] = req_ready;
        tick();
        // Scramble inputs: the adapter must work from its latched copy.
        req_valid     = 1'b0;
        req_addr      = 32'hFFFF_FFFC;
        req_we        = ~we;
        req_wdata     = 32'h0BAD_0BAD;
        req_wstrb     = ~ws;
        lat           = 0;
        s_pulse_after = 1'b1;
        for (int c = 1; c < 8; c++) begin
            s_addr[c]  = mem_addr;
            s_din[c]   = mem_din;
            s_mask[c]  = mem_maskwren;
            s_wren[c]  = mem_wren;
            s_ready[c] = req_ready;
            if (resp_valid) begin
                lat       = c;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                tick();
                s_pulse_after = resp_valid;
                break;
            end
            tick();
        end
    endtask

    int          pulses;
    int          pulses2;
    int          resp_cyc;
    int          resp_cyc2;
    logic [4:0]  ready_bits;
    logic [31:0] got2;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (3) tick();

        // Reset state
        check_vec("rst_ready", 32'(req_ready), 32'h1);
        check_vec("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_vec("rst_rdata", resp_rdata, 32'h0);
        check_vec("rst_err", 32'(resp_err), 32'h0);
        check_vec("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_vec("rst_mem_din", 32'(mem_din), 32'h0);
        check_vec("rst_mask", 32'(mem_maskwren), 32'h0);
        check_vec("rst_wren", 32'(mem_wren), 32'h0);
        reset = 1'b0;
        tick();

        // Full-word store
        txn(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
        check_vec("st1_ready_acc", 32'(s_ready[0]), 32'h1);
        check_vec("st1_ready_busy", 32'(s_ready[1]), 32'h0);
        check_vec("st1_addr_lo", 32'(s_addr[1]), 32'h008);
        check_vec("st1_din_lo", 32'(s_din[1]), 32'hBEEF);
        check_vec("st1_mask_lo", 32'(s_mask[1]), 32'hF);
        check_vec("st1_wren_lo", 32'(s_wren[1]), 32'h1);
        check_vec("st1_addr_hi", 32'(s_addr[2]), 32'h009);
        check_vec("st1_din_hi", 32'(s_din[2]), 32'hDEAD);
        check_vec("st1_mask_hi", 32'(s_mask[2]), 32'hF);
        check_vec("st1_lat", 32'(lat), 32'd3);
        check_vec("st1_rdata_held", resp_rdata, 32'h0);

        // Load back
        txn(32'h0000_0010, 1'b0, 32'h0, 4'h0);
        check_vec("ld1_lat", 32'(lat), 32'd4);
        check_vec("ld1_rdata", got_rdata, 32'hDEAD_BEEF);
        check_vec("ld1_pulse", 32'(s_pulse_after), 32'h0);
        check_vec("ld1_wren_lo", 32'(s_wren[1]), 32'h0);
        check_vec("ld1_mask_hi", 32'(s_mask[2]), 32'h0);
        check_vec("ld1_err", 32'(got_err), 32'h0);

        // Partial store (middle bytes), then load
        txn(32'h0000_0010, 1'b1, 32'h1122_3344, 4'b0110);
        check_vec("st2_mask_lo", 32'(s_mask[1]), 32'hC);
        check_vec("st2_mask_hi", 32'(s_mask[2]), 32'h3);
        check_vec("st2_rdata_held", resp_rdata, 32'hDEAD_BEEF);
        txn(32'h0000_0010, 1'b0, 32'h0, 4'h0);
        check_vec("ld2_rdata", got_rdata, 32'hDE22_33EF);

        // Zero-strobe store still runs the full sequence and changes nothing
        txn(32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0);
        check_vec("st0_lat", 32'(lat), 32'd3);
        check_vec("st0_wren", 32'(s_wren[1]), 32'h1);
        check_vec("st0_mask", 32'(s_mask[1]), 32'h0);
        txn(32'h0000_0010, 1'b0, 32'h0, 4'h0);
        check_vec("ld0_rdata", got_rdata, 32'hDE22_33EF);

        // Back-to-back loads with req_valid held high
        txn(32'h0000_0014, 1'b1, 32'h5A5A_A5A5, 4'hF);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0010;
        tick();
        pulses   = 0;
        resp_cyc = 0;
        got2     = '0;
        for (int c = 1; c <= 5; c++) begin
            ready_bits[c-1] = req_ready;
            if (resp_valid) begin
                pulses++;
                resp_cyc  = c;
                got_rdata = resp_rdata;
            end
            if (c == 5) req_addr = 32'h0000_0014;
            if (c < 5) tick();
        end
        tick();
        req_valid = 1'b0;
        pulses2   = 0;
        resp_cyc2 = 0;
        for (int c = 1; c <= 8; c++) begin
            if (resp_valid) begin
                pulses2++;
                resp_cyc2 = c;
                got2      = resp_rdata;
            end
            tick();
        end
        check_vec("b2b_ready_seq", 32'(ready_bits), 32'h10);
        check_vec("b2b_pulses1", 32'(pulses), 32'd1);
        check_vec("b2b_lat1", 32'(resp_cyc), 32'd4);
        check_vec("b2b_rdata1", got_rdata, 32'hDE22_33EF);
        check_vec("b2b_pulses2", 32'(pulses2), 32'd1);
        check_vec("b2b_lat2", 32'(resp_cyc2), 32'd4);
        check_vec("b2b_rdata2", got2, 32'h5A5A_A5A5);

        // Reset while a load is in ACC_HI
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0014;
        tick();
        req_valid = 1'b0;
        tick();
        check_vec("rmid_addr_hi", 32'(mem_addr), 32'h00B);
        reset = 1'b1;
        tick();
        check_vec("rmid_resp_valid", 32'(resp_valid), 32'h0);
        check_vec("rmid_ready", 32'(req_ready), 32'h1);
        check_vec("rmid_mem_addr", 32'(mem_addr), 32'h0);
        check_vec("rmid_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        txn(32'h0000_0010, 1'b0, 32'h0, 4'h0);
        check_vec("rpost_ready", 32'(s_ready[0]), 32'h1);
        check_vec("rpost_lat", 32'(lat), 32'd4);
        check_vec("rpost_rdata", got_rdata, 32'hDE22_33EF);

        // Out-of-window store
        txn(32'h0000_0000, 1'b1, 32'h1357_9BDF, 4'hF);
        txn(32'h0000_8000, 1'b1, 32'hCAFE_F00D, 4'hF);
        check_vec("oow_lat", 32'(lat), 32'd3);
`ifdef SPRAM_ADAPTER_ERR_EN
        check_vec("oow_wren_lo", 32'(s_wren[1]), 32'h0);
        check_vec("oow_wren_hi", 32'(s_wren[2]), 32'h0);
        check_vec("oow_mask_lo", 32'(s_mask[1]), 32'h0);
        check_vec("oow_err", 32'(got_err), 32'h1);
        txn(32'h0000_0000, 1'b0, 32'h0, 4'h0);
        check_vec("oow_w0_rdata", got_rdata, 32'h1357_9BDF);
        check_vec("oow_w0_err", 32'(got_err), 32'h0);
        txn(32'h0000_8000, 1'b0, 32'h0, 4'h0);
        check_vec("oow_ld_lat", 32'(lat), 32'd4);
        check_vec("oow_ld_rdata", got_rdata, 32'h0);
        check_vec("oow_ld_err", 32'(got_err), 32'h1);
`else
        check_vec("wrap_wren_lo", 32'(s_wren[1]), 32'h1);
        check_vec("wrap_addr_lo", 32'(s_addr[1]), 32'h000);
        check_vec("wrap_err", 32'(got_err), 32'h0);
        txn(32'h0000_0000, 1'b0, 32'h0, 4'h0);
        check_vec("wrap_w0_rdata", got_rdata, 32'hCAFE_F00D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
